// File: rtl/mux2_arbiter_if.sv
// Request/grant bundle between the requesters and the mux2_arbiter.
// The master side drives requests; the slave side (arbiter) drives grants and select.
interface mux2_arbiter_if;
  logic req0;
  logic req1;
  logic grant0;
  logic grant1;
  logic sel;
  logic busy;

  modport master (
    output req0,
    output req1,
    input  grant0,
    input  grant1,
    input  sel,
    input  busy
  );

  modport slave (
    input  req0,
    input  req1,
    output grant0,
    output grant1,
    output sel,
    output busy
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving the select of a shared mux2_1.
// A contested holder is preempted after MAX_HOLD granted cycles.
module mux2_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic           clk,
  input  logic           reset,
  mux2_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             grant0_q, grant0_d;
  logic             grant1_q, grant1_d;
  logic             busy_q, busy_d;
  logic             enter0, enter1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) state_d = last_q ? GRANT0 : GRANT1;
        else if (bus.req0)        state_d = GRANT0;
        else if (bus.req1)        state_d = GRANT1;
      end
      GRANT0: begin
        if (!bus.req0 && bus.req1)                 state_d = GRANT1;
        else if (!bus.req0 && !bus.req1)           state_d = IDLE;
        else if (bus.req1 && (cnt_q == CNT_MAX))   state_d = GRANT1;
      end
      GRANT1: begin
        if (!bus.req1 && bus.req0)                 state_d = GRANT0;
        else if (!bus.req1 && !bus.req0)           state_d = IDLE;
        else if (bus.req0 && (cnt_q == CNT_MAX))   state_d = GRANT0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry into a grant state (including preemption and handoff) restarts tenure
  // and moves sel together with the grant so no cycle sees a stale select.
  always_comb begin
    enter0 = (state_d == GRANT0) && (state_q != GRANT0);
    enter1 = (state_d == GRANT1) && (state_q != GRANT1);
    last_d = last_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    if (state_d == IDLE) begin
      cnt_d = '0;
    end else if (enter0) begin
      cnt_d  = '0;
      last_d = 1'b0;
      sel_d  = 1'b0;
    end else if (enter1) begin
      cnt_d  = '0;
      last_d = 1'b1;
      sel_d  = 1'b1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    grant0_d = (state_d == GRANT0);
    grant1_d = (state_d == GRANT1);
    busy_d   = grant0_d | grant1_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.grant0 = grant0_q;
  assign bus.grant1 = grant1_q;
  assign bus.sel    = sel_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed self-checking bench for mux2_arbiter with MAX_HOLD = 4.
// Outputs are compared as {grant0, grant1, sel, busy}.
module tb_mux2_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mux2_arbiter_if bus_if ();

  mux2_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {bus_if.grant0, bus_if.grant1, bus_if.sel, bus_if.busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_if.req0 = 1'b1;
    bus_if.req1 = 1'b1;
    #12;
    n_checks++;
    if (outs() !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs got %b exp %b", outs(), 4'b0000);
    end
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (outs() !== 4'b1001) begin
      n_fail++;
      $display("[TB] FAIL reset_first_tie got %b exp %b", outs(), 4'b1001);
    end
    bus_if.req0 = 1'b0;
    bus_if.req1 = 1'b0;
    tick();
    n_checks++;
    if (outs() !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_release_idle got %b exp %b", outs(), 4'b0000);
    end
  endtask

  task automatic test_single_requester();
    bus_if.req1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (outs() !== 4'b0111) begin
        n_fail++;
        $display("[TB] FAIL single_hold cycle %0d got %b exp %b", i, outs(), 4'b0111);
      end
    end
    bus_if.req1 = 1'b0;
    tick();
    n_checks++;
    if (outs() !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL single_release got %b exp %b", outs(), 4'b0010);
    end
  endtask

  task automatic test_preemption();
    logic [3:0] exp;
    bus_if.req0 = 1'b1;
    tick();
    n_checks++;
    if (outs() !== 4'b1001) begin
      n_fail++;
      $display("[TB] FAIL preempt_first got %b exp %b", outs(), 4'b1001);
    end
    bus_if.req1 = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      exp = (((i / 4) % 2) == 0) ? 4'b1001 : 4'b0111;
      n_checks++;
      if (outs() !== exp) begin
        n_fail++;
        $display("[TB] FAIL preempt_pattern cycle %0d got %b exp %b", i, outs(), exp);
      end
    end
    bus_if.req0 = 1'b0;
    bus_if.req1 = 1'b0;
    tick();
    n_checks++;
    if (outs() !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL preempt_idle got %b exp %b", outs(), 4'b0010);
    end
  endtask

  task automatic test_handoff();
    bus_if.req0 = 1'b1;
    tick();
    bus_if.req1 = 1'b1;
    tick();
    n_checks++;
    if (outs() !== 4'b1001) begin
      n_fail++;
      $display("[TB] FAIL handoff_holder got %b exp %b", outs(), 4'b1001);
    end
    bus_if.req0 = 1'b0;
    tick();
    n_checks++;
    if (outs() !== 4'b0111) begin
      n_fail++;
      $display("[TB] FAIL handoff_switch got %b exp %b", outs(), 4'b0111);
    end
    bus_if.req1 = 1'b0;
    tick();
    n_checks++;
    if (outs() !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL handoff_idle got %b exp %b", outs(), 4'b0010);
    end
  endtask

  task automatic test_tie_round_robin();
    bus_if.req0 = 1'b1;
    tick();
    bus_if.req0 = 1'b0;
    tick();
    n_checks++;
    if (outs() !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL tie_setup_idle got %b exp %b", outs(), 4'b0000);
    end
    bus_if.req0 = 1'b1;
    bus_if.req1 = 1'b1;
    tick();
    n_checks++;
    if (outs() !== 4'b0111) begin
      n_fail++;
      $display("[TB] FAIL tie_winner got %b exp %b", outs(), 4'b0111);
    end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL async_reset_drop got %b exp %b", outs(), 4'b0000);
    end
    tick();
    n_checks++;
    if (outs() !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL async_reset_held got %b exp %b", outs(), 4'b0000);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (outs() !== 4'b1001) begin
      n_fail++;
      $display("[TB] FAIL async_reset_recover got %b exp %b", outs(), 4'b1001);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_requester();
    test_preemption();
    test_handoff();
    test_tie_round_robin();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Two-requester round-robin arbiter that shares one 2:1 multiplexed resource (e.g. a shared LED/display drive line in the tug-of-war datapath) between player-side requesters. It registers requests, issues a one-hot grant, and drives the select line of the downstream `mux2_1`. It also bounds how long one requester can hold the resource while the other waits. Sits between the synchronized input/request logic and the shared `mux2_1` select.

## Interface

Parameters:
- `MAX_HOLD`, default 4: maximum consecutive granted cycles a holder keeps the resource while the other side is requesting. Legal range is 2..255.
- `CNT_W`, default `$clog2(MAX_HOLD)`: tenure counter width. It is derived, and is not overridden.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset. `reset`=0 clears all state immediately, independent of `clk`.
- `req0`, input, 1: request from requester 0. Level; held high for as long as access is wanted.
- `req1`, input, 1: request from requester 1. Same semantics as `req0`.
- `grant0`, output, 1: registered grant to requester 0.
- `grant1`, output, 1: registered grant to requester 1. Never high together with `grant0`.
- `sel`, output, 1: registered select for the downstream `mux2_1`. 1 routes `i1`, 0 routes `i0`.
- `busy`, output, 1: `grant0 | grant1`, registered.

## Operation

- States: IDLE, GRANT0, GRANT1. Internal state:
  - `last`: index of the most recent grantee.
  - `cnt`: tenure counter, `CNT_W` bits.
- Reset values:
  - state = IDLE
  - `grant0` = 0, `grant1` = 0, `busy` = 0
  - `sel` = 0
  - `last` = 1, so requester 0 wins the first tie
  - `cnt` = 0
- IDLE:
  - `req0 & req1`: go to GRANT of index `~last`.
  - `req0` only: go to GRANT0.
  - `req1` only: go to GRANT1.
  - Neither: stay in IDLE.
- GRANTx (x = holder, y = other):
  - `!reqx & reqy`: go to GRANTy. Direct handoff, no idle cycle.
  - `!reqx & !reqy`: go to IDLE.
  - `reqx & reqy & cnt == MAX_HOLD-1`: preempt and go to GRANTy.
  - Otherwise: stay in GRANTx.
- Counter:
  - Cleared to 0 on every entry into a GRANT state, and in IDLE.
  - Otherwise increments each cycle in GRANTx, saturating at MAX_HOLD-1.
  - It counts tenure regardless of `reqy`. Preemption only fires when `reqy` is high, so an uncontested holder keeps the grant indefinitely.
- `last` is updated to x on every entry into GRANTx.
- `sel` rules:
  - Set to 1 on entry to GRANT1 and to 0 on entry to GRANT0.
  - Holds its previous value in IDLE, so the mux output is not disturbed when nobody holds the resource.
- Grant outputs are a direct decode of the next state, registered.

## Timing

- Request-to-grant latency is 1 cycle: a request sampled at edge k gives grant high after edge k.
- Release latency is 1 cycle: `reqx` sampled low at edge k gives `grantx` low after edge k. In the same edge, `granty` rises if `reqy` is high.
- A contested holder sees at most MAX_HOLD cycles of grant.
- `sel` changes on the same edge as the grant it corresponds to. There is no cycle in which a grant is high with a stale `sel`.
- Glitches of `req` within a cycle are ignored; only edge-sampled values matter. Inputs must already be synchronized upstream.
- Asserting `reset` mid-grant forces all outputs to their reset values asynchronously. After deassertion, the first edge evaluates from IDLE with `last` = 1.
- Simultaneous release and other-request (`!reqx & reqy`) is a handoff, not a preemption: `cnt` is cleared and `last` = y.

## Test plan

- **Reset:** with `reset`=0 and `req0`=`req1`=1, all outputs are 0. Release reset, then at the first edge `grant0`=1, `sel`=0, `busy`=1.
- **Single requester:** `req1`=1 for 10 cycles, then 0. `grant1` is high for exactly 10 cycles starting one cycle after the request, and `sel`=1. After release `busy`=0 and `sel` stays 1.
- **Preemption (`MAX_HOLD`=4):** `req0`=1 first, then `req1`=1 one cycle later, both held. The grant pattern is 0,0,0,0,1,1,1,1,0,… alternating every 4 cycles, with `sel` tracking the grant.
- **Handoff:** `req0` granted, `req1` raised; drop `req0` after 2 cycles of grant. `grant1` rises on the same edge `grant0` falls, with no IDLE cycle.
- **Tie round-robin:** from IDLE with `last`=0, assert `req0`=`req1`=1 on the same edge. `grant1` wins.
- **Async reset mid-grant:** pulse `reset` low between clock edges while `grant1`=1. `grant1`, `sel` and `busy` drop without waiting for an edge.
